// File: rtl/aes_pkg.sv
// aes_pkg: shared round count, AES round-constant table and controller state type.
//   NUM_ROUNDS - expansion rounds per AES-128 schedule
//   NUM_KEYS   - stored round keys (round 0 plus one per round)
//   RCON       - round constants, indexed by round number 1..10 (other slots 0)
//   state_t    - controller FSM states
package aes_pkg;
   localparam int NUM_ROUNDS = 10;
   localparam int NUM_KEYS = NUM_ROUNDS + 1;
   localparam logic [7:0] RCON [0:15] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// aes_key_sched_ctrl_if: bundle of key intake, engine handshake, round-key read and status signals.
//   master - environment side (offers keys, acts as engine, issues reads)
//   slave  - controller side
interface aes_key_sched_ctrl_if;
   logic         key_valid;
   logic [127:0] key;
   logic         key_ready;
   logic         exp_in_valid;
   logic [127:0] exp_key;
   logic [7:0]   exp_rcon;
   logic         exp_out_valid;
   logic [127:0] exp_round_key;
   logic         rk_rd_en;
   logic [3:0]   rk_rd_idx;
   logic         rk_rd_valid;
   logic [127:0] rk_rd_data;
   logic         rk_rd_err;
   logic         sched_done;
   logic         sched_err;
   modport master (
      output key_valid, key, exp_out_valid, exp_round_key, rk_rd_en, rk_rd_idx,
      input  key_ready, exp_in_valid, exp_key, exp_rcon, rk_rd_valid, rk_rd_data,
             rk_rd_err, sched_done, sched_err
   );
   modport slave (
      input  key_valid, key, exp_out_valid, exp_round_key, rk_rd_en, rk_rd_idx,
      output key_ready, exp_in_valid, exp_key, exp_rcon, rk_rd_valid, rk_rd_data,
             rk_rd_err, sched_done, sched_err
   );
endinterface

// File: rtl/aes_rk_regfile.sv
// aes_rk_regfile: 11x128 round-key storage, one write port, one registered read port.
//   clk, reset_n      - clock, asynchronous active-low reset (read register only)
//   wr_en_i/idx/data  - write port, entry updated at the clock edge
//   rd_en_i/rd_idx_i  - read request, index must be 0..10
//   rd_data_o         - read data, one cycle after the request; a same-cycle
//                       write to the same entry returns the old contents
module aes_rk_regfile
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr_en_i,
   input  logic [3:0]   wr_idx_i,
   input  logic [127:0] wr_data_i,
   input  logic         rd_en_i,
   input  logic [3:0]   rd_idx_i,
   output logic [127:0] rd_data_o
);
   logic [127:0] mem_q [NUM_KEYS];
   logic [127:0] rd_data_q;
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
   end
   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: drives an external AES-128 expansion engine through ten rounds and serves the round keys.
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - slave side of aes_key_sched_ctrl_if: key intake (key_valid/key/key_ready),
//             engine request (exp_in_valid/exp_key/exp_rcon) and result (exp_out_valid/
//             exp_round_key), round-key read (rk_rd_*), status (sched_done/sched_err)
// Build option KEY_SCHED_WATCHDOG_EN: per-round engine timeout of TIMEOUT_CYCLES
// WAIT cycles, which sets the sticky sched_err and returns to IDLE.
module aes_key_sched_ctrl
   import aes_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                 clk,
   input logic                 reset_n,
   aes_key_sched_ctrl_if.slave bus
);
   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
   state_t       state_q, state_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] prev_q, prev_d;
   logic         rd_valid_q, rd_valid_d, rd_err_q, rd_err_d, rd_show_q, rd_show_d;
   logic         busy, accept, timeout, in_range, readable, collide;
   logic         wr_en;
   logic [3:0]   wr_idx;
   logic [127:0] wr_data, rf_data;
   assign busy = state_q == ISSUE || state_q == WAIT;
   assign accept = !busy && bus.key_valid;
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      prev_d  = prev_q;
      wr_en   = 1'b0;
      wr_idx  = round_q;
      wr_data = bus.exp_round_key;
      case (state_q)
         IDLE, DONE: if (accept) begin
            state_d = ISSUE;
            round_d = 4'd1;
            prev_d  = bus.key;
            wr_en   = 1'b1;
            wr_idx  = '0;
            wr_data = bus.key;
         end
         ISSUE: state_d = WAIT;
         WAIT: if (bus.exp_out_valid) begin
            wr_en   = 1'b1;
            prev_d  = bus.exp_round_key;
            state_d = (round_q == LAST) ? DONE : ISSUE;
            round_d = (round_q == LAST) ? round_q : round_q + 4'd1;
         end else if (timeout) begin
            state_d = IDLE;
            round_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   // Entries below the current round are final; everything is final in DONE.
   // A read that collides with the write of its own entry sees the old contents
   // but is still flagged as an error because the entry is not yet valid.
   assign in_range   = bus.rk_rd_idx <= LAST;
   assign readable   = in_range && (state_q == DONE || (busy && bus.rk_rd_idx < round_q));
   assign collide    = wr_en && bus.rk_rd_idx == wr_idx && !readable;
   assign rd_valid_d = bus.rk_rd_en && readable;
   assign rd_err_d   = bus.rk_rd_en && !readable;
   assign rd_show_d  = bus.rk_rd_en && (readable || collide);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         round_q    <= '0;
         prev_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_show_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         prev_q     <= prev_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         rd_show_q  <= rd_show_d;
      end
   end
   aes_rk_regfile u_rf (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (wr_en),
      .wr_idx_i  (wr_idx),
      .wr_data_i (wr_data),
      .rd_en_i   (bus.rk_rd_en && in_range),
      .rd_idx_i  (bus.rk_rd_idx),
      .rd_data_o (rf_data)
   );
`ifdef KEY_SCHED_WATCHDOG_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDW-1:0] wd_q, wd_d;
   logic           err_q, err_d;
   assign wd_d    = (state_q == WAIT) ? wd_q + 1'b1 : '0;
   assign timeout = state_q == WAIT && wd_q == WDW'(TIMEOUT_CYCLES - 1);
   assign err_d   = !accept && (err_q || (timeout && !bus.exp_out_valid));
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end
   assign bus.sched_err = err_q;
`else
   logic unused_tmo;
   assign unused_tmo    = TIMEOUT_CYCLES[0];
   assign timeout       = 1'b0;
   assign bus.sched_err = 1'b0;
`endif
   assign bus.key_ready    = !busy;
   assign bus.exp_in_valid = state_q == ISSUE;
   assign bus.exp_key      = (state_q == ISSUE) ? prev_q : '0;
   assign bus.exp_rcon     = (state_q == ISSUE) ? RCON[round_q] : '0;
   assign bus.rk_rd_valid  = rd_valid_q;
   assign bus.rk_rd_err    = rd_err_q;
   assign bus.rk_rd_data   = rd_show_q ? rf_data : '0;
   assign bus.sched_done   = state_q == DONE;
endmodule
